// File: rtl/unroller_pkg.sv
// Shared helpers for the unroller slice: sizing of the per-vector beat counter.
package unroller_pkg;

    // One bit wider than strictly needed so CYCLES=1 still yields a legal 1-bit counter.
    function automatic int unsigned beat_cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/unroller_bank.sv
// One ping-pong bank of the unroller: NUM-element register file written one
// ROLL_NUM-wide beat at a time, plus the full flag that gates its visibility.
module unroller_bank
    import unroller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM        = 8,
    parameter int unsigned ROLL_NUM   = 2,
    parameter int unsigned IDX_W      = beat_cnt_width(NUM / ROLL_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data [ROLL_NUM],
    input  logic                  set_full,
    input  logic                  clr_full,
    output logic [DATA_WIDTH-1:0] data [NUM],
    output logic                  full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                data[i] <= '0;
            end
            full <= 1'b0;
        end else begin
            // Element i belongs to beat i/ROLL_NUM, lane i%ROLL_NUM.
            for (int unsigned i = 0; i < NUM; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i / ROLL_NUM))) begin
                    data[i] <= wr_data[i % ROLL_NUM];
                end
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/unroller.sv
// Reassembles groups of NUM/ROLL_NUM input beats into NUM-wide vectors using
// two ping-pong banks so filling and draining overlap.
module unroller
    import unroller_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM        = 8,
    parameter int unsigned ROLL_NUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int unsigned CYCLES = NUM / ROLL_NUM;
    localparam int unsigned CNT_W  = beat_cnt_width(CYCLES);

    logic                  wr_bank;
    logic                  rd_bank;
    logic [CNT_W-1:0]      beat_cnt;
    logic [1:0]            full;
    logic                  accept;
    logic                  pop;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] bank0_data [NUM];
    logic [DATA_WIDTH-1:0] bank1_data [NUM];

    unroller_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM        (NUM),
        .ROLL_NUM   (ROLL_NUM),
        .IDX_W      (CNT_W)
    ) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && !wr_bank),
        .wr_idx   (beat_cnt),
        .wr_data  (data_in),
        .set_full (accept && last_beat && !wr_bank),
        .clr_full (pop && !rd_bank),
        .data     (bank0_data),
        .full     (full[0])
    );

    unroller_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM        (NUM),
        .ROLL_NUM   (ROLL_NUM),
        .IDX_W      (CNT_W)
    ) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && wr_bank),
        .wr_idx   (beat_cnt),
        .wr_data  (data_in),
        .set_full (accept && last_beat && wr_bank),
        .clr_full (pop && rd_bank),
        .data     (bank1_data),
        .full     (full[1])
    );

    // Ready comes only from the bank flags, never from data_out_ready.
    always_comb begin
        data_in_ready  = !full[wr_bank];
        data_out_valid = full[rd_bank];
        accept         = data_in_valid && data_in_ready;
        pop            = data_out_valid && data_out_ready;
        last_beat      = (beat_cnt == CNT_W'(CYCLES - 1));
        for (int unsigned i = 0; i < NUM; i++) begin
            data_out[i] = rd_bank ? bank1_data[i] : bank0_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    wr_bank  <= !wr_bank;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_bank <= !rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_unroller.sv
// Bench for unroller: two instances (NUM=8 and NUM=2, ROLL_NUM=2) checked every
// cycle against a queue-of-vectors model, plus literal spot checks.
module tb_unroller;

    localparam int unsigned DW = 16;
    localparam logic [127:0] SEQ8 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] a_in [2];
    logic          a_in_valid;
    logic          a_in_ready;
    logic [DW-1:0] a_out [8];
    logic          a_out_valid;
    logic          a_out_ready;
    logic [DW-1:0] b_in [2];
    logic          b_in_valid;
    logic          b_in_ready;
    logic [DW-1:0] b_out [2];
    logic          b_out_valid;
    logic          b_out_ready;

    unroller #(.DATA_WIDTH(DW), .NUM(8), .ROLL_NUM(2)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .data_in        (a_in),
        .data_in_valid  (a_in_valid),
        .data_in_ready  (a_in_ready),
        .data_out       (a_out),
        .data_out_valid (a_out_valid),
        .data_out_ready (a_out_ready)
    );

    unroller #(.DATA_WIDTH(DW), .NUM(2), .ROLL_NUM(2)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .data_in        (b_in),
        .data_in_valid  (b_in_valid),
        .data_in_ready  (b_in_ready),
        .data_out       (b_out),
        .data_out_valid (b_out_valid),
        .data_out_ready (b_out_ready)
    );

    int cmp_count = 0;
    int err_count = 0;
    int pops_a = 0;
    int pops_b = 0;
    bit armed = 1'b0;

    // Model: completed vectors waiting for the consumer (at most two) plus the partial group.
    logic [127:0] qa [$];
    logic [127:0] qb [$];
    logic [127:0] part_a = '0;
    int           na = 0;

    function automatic logic [127:0] vec_a();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = a_out[i];
        return v;
    endfunction

    function automatic logic [127:0] vec_b();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 2; i++) v[16*i +: 16] = b_out[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        cmp_count++;
        if (act != exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic acc, pp;
        if (armed) begin
            chk("a_in_ready", a_in_ready, qa.size() < 2);
            chk("a_out_valid", a_out_valid, qa.size() != 0);
            if (qa.size() != 0) chk_vec("a_data_out", vec_a(), qa[0]);
            chk("b_in_ready", b_in_ready, qb.size() < 2);
            chk("b_out_valid", b_out_valid, qb.size() != 0);
            if (qb.size() != 0) chk_vec("b_data_out", vec_b(), qb[0]);
        end
        if (rst) begin
            armed = 1'b1;
            qa.delete();
            qb.delete();
            na = 0;
            part_a = '0;
        end else if (armed) begin
            pp  = (qa.size() != 0) && a_out_ready;
            acc = a_in_valid && (qa.size() < 2);
            if (pp) begin
                void'(qa.pop_front());
                pops_a++;
            end
            if (acc) begin
                part_a[32*na +: 32] = {a_in[1], a_in[0]};
                na++;
                if (na == 4) begin
                    qa.push_back(part_a);
                    na = 0;
                end
            end
            pp  = (qb.size() != 0) && b_out_ready;
            acc = b_in_valid && (qb.size() < 2);
            if (pp) begin
                void'(qb.pop_front());
                pops_b++;
            end
            if (acc) qb.push_back({96'b0, b_in[1], b_in[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        logic took;
        took = 1'b0;
        a_in[0] = e0;
        a_in[1] = e1;
        a_in_valid = 1'b1;
        for (int n = 0; n < 100 && !took; n++) begin
            @(negedge clk);
            took = a_in_ready;
            tick();
        end
        a_in_valid = 1'b0;
        chk("send_a_accepted", took, 1'b1);
    endtask

    task automatic send_b(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        logic took;
        took = 1'b0;
        b_in[0] = e0;
        b_in[1] = e1;
        b_in_valid = 1'b1;
        for (int n = 0; n < 100 && !took; n++) begin
            @(negedge clk);
            took = b_in_ready;
            tick();
        end
        b_in_valid = 1'b0;
        chk("send_b_accepted", took, 1'b1);
    endtask

    task automatic expect_vec_a(input string name, input logic [127:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, a_out_valid, 1'b1);
        chk_vec({name, "_vec"}, vec_a(), exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p0;
        bit  done;
        bit  gap_pat [7];
        int  k;
        gap_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in[0] = '0; a_in[1] = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in[0] = '0; b_in[1] = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_a_ready", a_in_ready, 1'b1);
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk_vec("rst_a_zero", vec_a(), '0);
        chk("rst_b_valid", b_out_valid, 1'b0);
        tick();

        // Basic fill, single-cycle presentation
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_a(DW'(2*i), DW'(2*i+1));
        expect_vec_a("basic", SEQ8);
        @(negedge clk);
        chk("basic_one_cycle", a_out_valid, 1'b0);
        tick();

        // Backpressure: both banks fill, ready drops, output held
        a_out_ready = 1'b0;
        p0 = pops_a;
        for (int i = 0; i < 8; i++) send_a(DW'(2*i), DW'(2*i+1));
        @(negedge clk);
        chk("bp_ready_low", a_in_ready, 1'b0);
        chk_vec("bp_held", vec_a(), SEQ8);
        tick();
        fork
            begin
                repeat (3) tick();
                @(negedge clk);
                chk_vec("bp_still_held", vec_a(), SEQ8);
                tick();
                a_out_ready = 1'b1;
            end
            begin
                for (int i = 8; i < 12; i++) send_a(DW'(2*i), DW'(2*i+1));
            end
        join
        repeat (6) tick();
        chk_int("bp_three_vectors", pops_a - p0, 3);

        // Input gaps
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (gap_pat[i]) begin
                send_a(DW'(2*k), DW'(2*k+1));
                k++;
            end else begin
                tick();
            end
        end
        expect_vec_a("gaps", SEQ8);

        // Reset mid-fill; valid during the reset cycle is ignored
        p0 = pops_a;
        send_a(DW'(9), DW'(9));
        send_a(DW'(9), DW'(9));
        a_in[0] = DW'(9); a_in[1] = DW'(9); a_in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_a(DW'(2*i), DW'(2*i+1));
        expect_vec_a("rst_mid", SEQ8);
        repeat (3) tick();
        chk_int("rst_single_vector", pops_a - p0, 1);

        // CYCLES=1: sustained throughput, then random consumer
        p0 = pops_b;
        b_out_ready = 1'b1;
        for (int n = 0; n < 10; n++) send_b(DW'(2*n), DW'(2*n+1));
        done = 1'b0;
        fork
            begin
                for (int n = 10; n < 50; n++) send_b(DW'(2*n), DW'(2*n+1));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    b_out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        b_out_ready = 1'b1;
        repeat (4) tick();
        chk_int("b_all_vectors", pops_b - p0, 50);

        // Random traffic on the NUM=8 instance
        for (int n = 0; n < 300; n++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_in[0] = DW'($urandom);
            a_in[1] = DW'($urandom);
            tick();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
